axis_pkt_merge: RTL and testbench

Parametrised N-to-1 AXI-Stream packet merger for the data_route output path. It generalises the two-input OR-merge, which required mutually exclusive valids, to NCH independent producers. Arbitration is round-robin and packet-atomic: a granted channel keeps the output until its tlast beat. The merged stream leaves through an internal 2-entry skid buffer toward the DMA/output port.

---
 rtl/axis_merge_pkg.sv | 36 +++
 rtl/axis_skid_buf.sv | 69 ++++++
 rtl/axis_pkt_merge.sv | 115 +++++++++++
 tb/tb_axis_pkt_merge.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_merge_pkg.sv
// Shared types and helpers for the N-to-1 AXI-Stream packet merger.
// Optional channel-id sideband is enabled by defining AXIS_MERGE_TID_EN.
package axis_merge_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    localparam int MAX_CH = 16;

    // Index width for a channel count; never narrower than one bit.
    function automatic int cw(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    // Round-robin winner: first set valid bit searching last+1, last+2, ... modulo n.
    function automatic logic [3:0] rr_pick(input logic [MAX_CH-1:0] valid,
                                           input logic [3:0]        last,
                                           input int                n);
        logic [3:0] win;
        logic       found;
        int         idx;
        win   = last;
        found = 1'b0;
        for (int i = 1; i <= MAX_CH; i++) begin
            idx = (int'(last) + i) % n;
            if (i <= n && !found && valid[idx[3:0]]) begin
                win   = idx[3:0];
                found = 1'b1;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/axis_skid_buf.sv
// Two-entry FIFO-ordered skid buffer; full registered, one transfer per cycle each side.
// The writer must not write while full is high.
module axis_skid_buf #(
    parameter int PWIDTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [PWIDTH-1:0] in_data,
    output logic              full,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PWIDTH-1:0] out_data
);

    logic [1:0]        count_q, count_d;
    logic [PWIDTH-1:0] head_q, head_d;
    logic [PWIDTH-1:0] tail_q, tail_d;
    logic              full_q, full_d;
    logic              rd;

    always_comb begin
        rd      = (count_q != 2'd0) & out_ready;
        count_d = count_q;
        head_d  = head_q;
        tail_d  = tail_q;
        case ({in_valid, rd})
            2'b10: begin
                if (count_q == 2'd0) head_d = in_data;
                else                 tail_d = in_data;
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                head_d  = tail_q;
                count_d = count_q - 2'd1;
            end
            2'b11: begin
                // Count is unchanged; the new beat lands behind whatever remains.
                if (count_q == 2'd1) begin
                    head_d = in_data;
                end else begin
                    head_d = tail_q;
                    tail_d = in_data;
                end
            end
            default: ;
        endcase
        full_d = (count_d == 2'd2);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= 2'd0;
            head_q  <= '0;
            tail_q  <= '0;
            full_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            full_q  <= full_d;
        end
    end

    assign full      = full_q;
    assign out_valid = (count_q != 2'd0);
    assign out_data  = head_q;

endmodule

// File: rtl/axis_pkt_merge.sv
// N-to-1 AXI-Stream merger with packet-atomic round-robin arbitration and a 2-entry output skid.
// Define AXIS_MERGE_TID_EN to add the m_axis_tid source-channel output.
module axis_pkt_merge
    import axis_merge_pkg::*;
#(
    parameter int DWIDTH = 128,
    parameter int NCH    = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NCH*DWIDTH-1:0] s_axis_tdata,
    input  logic [NCH-1:0]        s_axis_tvalid,
    output logic [NCH-1:0]        s_axis_tready,
    input  logic [NCH-1:0]        s_axis_tlast,
    output logic [DWIDTH-1:0]     m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast
`ifdef AXIS_MERGE_TID_EN
    ,
    output logic [cw(NCH)-1:0]    m_axis_tid
`endif
);

    localparam int CW = cw(NCH);
`ifdef AXIS_MERGE_TID_EN
    localparam int PWIDTH = DWIDTH + 1 + CW;
`else
    localparam int PWIDTH = DWIDTH + 1;
`endif

    if (NCH < 2 || NCH > MAX_CH) begin : g_nch_check
        $error("axis_pkt_merge: NCH must be in 2..16");
    end

    arb_state_t         state_q, state_d;
    logic [CW-1:0]      gnt_q, gnt_d;
    logic [CW-1:0]      last_q, last_d;
    logic [MAX_CH-1:0]  valid_ext;
    logic [3:0]         last_ext;
    logic               skid_full;
    logic               beat_acc;
    logic [PWIDTH-1:0]  wr_pay;
    logic [PWIDTH-1:0]  rd_pay;

    always_comb begin
        valid_ext             = '0;
        valid_ext[NCH-1:0]    = s_axis_tvalid;
        last_ext              = '0;
        last_ext[CW-1:0]      = last_q;
    end

    // Valid/ready: a beat moves only in a cycle where both are high; the granted
    // channel sees ready whenever the skid has room, and nothing preempts it before tlast.
    always_comb begin
        state_d       = state_q;
        gnt_d         = gnt_q;
        last_d        = last_q;
        s_axis_tready = '0;
        beat_acc      = 1'b0;
        case (state_q)
            IDLE: begin
                if (|s_axis_tvalid) begin
                    gnt_d   = CW'(rr_pick(valid_ext, last_ext, NCH));
                    state_d = BUSY;
                end
            end
            BUSY: begin
                s_axis_tready[gnt_q] = ~skid_full;
                beat_acc             = s_axis_tvalid[gnt_q] & ~skid_full;
                if (beat_acc && s_axis_tlast[gnt_q]) begin
                    state_d = IDLE;
                    last_d  = gnt_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            last_q  <= CW'(NCH - 1);
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
        end
    end

`ifdef AXIS_MERGE_TID_EN
    assign wr_pay = {gnt_q, s_axis_tlast[gnt_q], s_axis_tdata[gnt_q*DWIDTH +: DWIDTH]};
    assign m_axis_tid = rd_pay[DWIDTH+1 +: CW];
`else
    assign wr_pay = {s_axis_tlast[gnt_q], s_axis_tdata[gnt_q*DWIDTH +: DWIDTH]};
`endif

    axis_skid_buf #(
        .PWIDTH (PWIDTH)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (beat_acc),
        .in_data   (wr_pay),
        .full      (skid_full),
        .out_valid (m_axis_tvalid),
        .out_ready (m_axis_tready),
        .out_data  (rd_pay)
    );

    assign m_axis_tdata = rd_pay[DWIDTH-1:0];
    assign m_axis_tlast = rd_pay[DWIDTH];

endmodule

// File: tb/tb_axis_pkt_merge.sv
// Self-checking bench for axis_pkt_merge: directed scenarios plus a randomized run
// scored against a round-robin packet-order model.
module tb_axis_pkt_merge;

    localparam int DWIDTH = 128;
    localparam int NCH    = 4;
    localparam int TIDW   = 2;
    localparam int W      = DWIDTH + 1 + TIDW;

    typedef struct packed {
        logic              first;
        logic              last;
        logic [DWIDTH-1:0] data;
    } beat_t;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [NCH*DWIDTH-1:0] s_axis_tdata;
    logic [NCH-1:0]        s_axis_tvalid;
    logic [NCH-1:0]        s_axis_tready;
    logic [NCH-1:0]        s_axis_tlast;
    logic [DWIDTH-1:0]     m_axis_tdata;
    logic                  m_axis_tvalid;
    logic                  m_axis_tready;
    logic                  m_axis_tlast;
`ifdef AXIS_MERGE_TID_EN
    logic [TIDW-1:0]       m_axis_tid;
`endif

    always #5 clk = ~clk;

    axis_pkt_merge #(
        .DWIDTH (DWIDTH),
        .NCH    (NCH)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast)
`ifdef AXIS_MERGE_TID_EN
        ,
        .m_axis_tid    (m_axis_tid)
`endif
    );

    beat_t          src_q[NCH][$];
    logic [W-1:0]   exp_q[$];
    int             out_cyc_q[$];
    int             n_checks = 0;
    int             n_err    = 0;
    int             cyc      = 0;
    int             n_out    = 0;
    int             acc_cnt  = 0;
    int             t0       = 0;
    bit             gap_en      = 1'b0;
    bit             mready_rand = 1'b0;
    logic           mready_val  = 1'b1;
    logic           prev_hold   = 1'b0;
    logic [DWIDTH:0] prev_pay;
    logic [NCH-1:0] smp_tready;
    logic           smp_mvalid;
    logic [DWIDTH-1:0] smp_mdata;

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    function automatic bit src_pending();
        for (int c = 0; c < NCH; c++) if (src_q[c].size() != 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic add_pkt(input int c, input int len, input logic [DWIDTH-1:0] base,
                           input logic [DWIDTH-1:0] stp, input bit to_exp);
        beat_t b;
        logic [DWIDTH-1:0] d;
        d = base;
        for (int i = 0; i < len; i++) begin
            b.first = (i == 0);
            b.last  = (i == len - 1);
            b.data  = d;
            src_q[c].push_back(b);
            if (to_exp) exp_q.push_back({TIDW'(c), b.last, b.data});
            d = d + stp;
        end
    endtask

    // Packet order from the round-robin rule: starting after the previous winner,
    // the next channel that still has a packet waiting sends its whole packet.
    task automatic build_expected();
        beat_t mq[NCH][$];
        beat_t b;
        int    last;
        int    idx;
        bit    found;
        bit    more;
        for (int c = 0; c < NCH; c++) mq[c] = src_q[c];
        last = NCH - 1;
        idx  = 0;
        more = 1'b1;
        while (more) begin
            found = 1'b0;
            for (int i = 1; i <= NCH; i++) begin
                if (!found && mq[(last + i) % NCH].size() != 0) begin
                    idx   = (last + i) % NCH;
                    found = 1'b1;
                end
            end
            if (!found) begin
                more = 1'b0;
            end else begin
                do begin
                    b = mq[idx].pop_front();
                    exp_q.push_back({TIDW'(idx), b.last, b.data});
                end while (!b.last);
                last = idx;
            end
        end
    endtask

    task automatic drive_inputs(input logic [NCH-1:0] acc);
        logic v;
        for (int c = 0; c < NCH; c++) begin
            if (src_q[c].size() == 0) begin
                v = 1'b0;
                s_axis_tdata[c*DWIDTH +: DWIDTH] = '0;
                s_axis_tlast[c] = 1'b0;
            end else begin
                if (s_axis_tvalid[c] && !acc[c]) v = 1'b1;
                else if (src_q[c][0].first || !gap_en) v = 1'b1;
                else v = ($urandom_range(0, 2) != 0);
                s_axis_tdata[c*DWIDTH +: DWIDTH] = src_q[c][0].data;
                s_axis_tlast[c] = src_q[c][0].last;
            end
            s_axis_tvalid[c] = v;
        end
        m_axis_tready = mready_rand ? ($urandom_range(0, 3) != 0) : mready_val;
    endtask

    task automatic step();
        logic [NCH-1:0] acc;
        logic [W-1:0]   e;
        @(negedge clk);
        smp_tready = s_axis_tready;
        smp_mvalid = m_axis_tvalid;
        smp_mdata  = m_axis_tdata;
        chk("tready_onehot", ($countones(s_axis_tready) <= 1), 1);
        if (prev_hold) begin
            chk("hold_valid", m_axis_tvalid, 1);
            chk("hold_payload", {m_axis_tlast, m_axis_tdata}, prev_pay);
        end
        prev_hold = m_axis_tvalid & ~m_axis_tready;
        prev_pay  = {m_axis_tlast, m_axis_tdata};
        if (m_axis_tvalid && m_axis_tready) begin
            chk("out_expected", (exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("out_beat", {m_axis_tlast, m_axis_tdata}, e[DWIDTH:0]);
`ifdef AXIS_MERGE_TID_EN
                chk("out_tid", m_axis_tid, e[W-1 -: TIDW]);
`endif
            end
            out_cyc_q.push_back(cyc);
            n_out++;
        end
        acc = s_axis_tvalid & s_axis_tready;
        @(posedge clk);
        #1;
        cyc++;
        for (int c = 0; c < NCH; c++) begin
            if (acc[c]) begin
                void'(src_q[c].pop_front());
                acc_cnt++;
            end
        end
        drive_inputs(acc);
    endtask

    task automatic drain(input int bound);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || src_pending()) && n < bound) begin
            step();
            n++;
        end
        chk("drain_complete", (exp_q.size() == 0 && !src_pending()), 1);
        repeat (3) step();
    endtask

    task automatic do_reset(input int ncyc);
        rst_n         = 1'b0;
        s_axis_tvalid = '0;
        s_axis_tlast  = '0;
        s_axis_tdata  = '0;
        m_axis_tready = mready_val;
        for (int c = 0; c < NCH; c++) src_q[c].delete();
        exp_q.delete();
        prev_hold = 1'b0;
        repeat (ncyc) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_mvalid", m_axis_tvalid, 0);
        chk("rst_tready", s_axis_tready, 0);
        chk("rst_mdata", m_axis_tdata, 0);
        chk("rst_mlast", m_axis_tlast, 0);
`ifdef AXIS_MERGE_TID_EN
        chk("rst_mtid", m_axis_tid, 0);
`endif
        @(posedge clk);
        #1;
        cyc = cyc + ncyc + 1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        int n;
        rst_n         = 1'b0;
        s_axis_tvalid = '0;
        s_axis_tlast  = '0;
        s_axis_tdata  = '0;
        m_axis_tready = 1'b0;

        // Single channel: ch2, 3 beats, outputs at cycles 2,3,4 after first valid.
        mready_val = 1'b1;
        do_reset(3);
        add_pkt(2, 3, 128'h11, 128'h11, 1'b1);
        out_cyc_q.delete();
        drive_inputs('0);
        t0 = cyc;
        drain(100);
        chk("t1_nbeats", out_cyc_q.size(), 3);
        if (out_cyc_q.size() == 3)
            for (int j = 0; j < 3; j++) chk("t1_out_cycle", out_cyc_q[j], t0 + 2 + j);

        // Round-robin over continuously busy channels: order 0,1,2,3,0 with one bubble per packet.
        do_reset(1);
        add_pkt(0, 2, 128'h0000, 128'h1, 1'b0);
        add_pkt(1, 2, 128'h1000, 128'h1, 1'b0);
        add_pkt(2, 2, 128'h2000, 128'h1, 1'b0);
        add_pkt(3, 2, 128'h3000, 128'h1, 1'b0);
        add_pkt(0, 2, 128'h0100, 128'h1, 1'b0);
        build_expected();
        out_cyc_q.delete();
        drive_inputs('0);
        t0 = cyc;
        drain(200);
        chk("t2_nbeats", out_cyc_q.size(), 10);
        if (out_cyc_q.size() == 10)
            for (int j = 0; j < 10; j++)
                chk("t2_out_cycle", out_cyc_q[j], t0 + 2 + 3 * (j / 2) + (j % 2));

        // Packet lock: ch0 raises valid while ch1 is mid-packet.
        do_reset(1);
        add_pkt(1, 5, 128'hA10, 128'h1, 1'b1);
        drive_inputs('0);
        repeat (3) step();
        add_pkt(0, 2, 128'hB00, 128'h1, 1'b1);
        n = 0;
        while (src_q[1].size() != 0 && n < 50) begin
            step();
            chk("t3_lock_ch0_tready", smp_tready[0], 0);
            n++;
        end
        drain(100);

        // Backpressure: downstream stalled, exactly two beats absorbed.
        mready_val = 1'b0;
        do_reset(1);
        add_pkt(0, 8, 128'hC00, 128'h3, 1'b1);
        acc_cnt = 0;
        n_out   = 0;
        drive_inputs('0);
        repeat (6) step();
        chk("t4_absorbed", acc_cnt, 2);
        chk("t4_tready_low", smp_tready, 0);
        chk("t4_mvalid", smp_mvalid, 1);
        chk("t4_head_data", smp_mdata, 128'hC00);
        mready_val = 1'b1;
        drain(200);
        chk("t4_nbeats", n_out, 8);

        // Reset mid-packet, then ch0 wins first.
        do_reset(1);
        add_pkt(1, 6, 128'hD00, 128'h1, 1'b1);
        n_out = 0;
        drive_inputs('0);
        n = 0;
        while (n_out < 3 && n < 50) begin
            step();
            n++;
        end
        chk("t5_three_out", n_out, 3);
        do_reset(1);
        add_pkt(0, 2, 128'hE00, 128'h1, 1'b0);
        add_pkt(1, 2, 128'hE10, 128'h1, 1'b0);
        build_expected();
        drive_inputs('0);
        drain(100);

        // Single-beat packets alternate 0,1,0,1 at one beat per two cycles.
        do_reset(1);
        for (int k = 0; k < 4; k++) begin
            add_pkt(0, 1, 128'hF00 + 128'(k), 128'h0, 1'b0);
            add_pkt(1, 1, 128'hF10 + 128'(k), 128'h0, 1'b0);
        end
        build_expected();
        out_cyc_q.delete();
        drive_inputs('0);
        t0 = cyc;
        drain(100);
        chk("t6_nbeats", out_cyc_q.size(), 8);
        if (out_cyc_q.size() == 8)
            for (int j = 0; j < 8; j++) chk("t6_out_cycle", out_cyc_q[j], t0 + 2 + 2 * j);

        // Randomized traffic with valid gaps and random downstream ready.
        do_reset(1);
        gap_en      = 1'b1;
        mready_rand = 1'b1;
        for (int c = 0; c < NCH; c++) begin
            n = $urandom_range(1, 4);
            for (int p = 0; p < n; p++)
                add_pkt(c, $urandom_range(1, 5), {$urandom, $urandom, $urandom, $urandom},
                        {$urandom, $urandom, $urandom, $urandom}, 1'b0);
        end
        build_expected();
        drive_inputs('0);
        drain(4000);
        gap_en      = 1'b0;
        mready_rand = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
